// File: rtl/mc_controller.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath enables, mux selects and ALUOp for the downstream ALU decoder.
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       BranchCond,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       Illegal
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite, StExecR, StExecI,
        StAluWb, StBranch, StJal, StJalr, StJalr2, StLui, StAuipc
    } state_e;

    state_e state_q, state_d;

    logic mem_req, pc_update, mem_write, ir_write, reg_write, illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StFetch;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:    state_d = MemReady ? StDecode : StFetch;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui:           state_d = StLui;
                    OpAuipc:         state_d = StAuipc;
                    default:         state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = op[5] ? StMemWrite : StMemRead;
            StMemRead:  state_d = MemReady ? StMemWb : StMemRead;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = MemReady ? StFetch : StMemWrite;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StJal:      state_d = StAluWb;
            StJalr:     state_d = StJalr2;
            StJalr2:    state_d = StAluWb;
            StLui:      state_d = StAluWb;
            StAuipc:    state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        pc_update = 1'b0;
        AdrSrc    = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        illegal   = 1'b0;
        case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = MemReady;
                pc_update = MemReady;
            end
            StDecode: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OpLoad, OpStore, OpR, OpI, OpBranch, OpJal, OpJalr, OpLui, OpAuipc:
                        illegal = 1'b0;
                    default: illegal = 1'b1;
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StMemRead: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
            end
            StMemWb: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            StExecR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            StExecI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            StAluWb: reg_write = 1'b1;
            StBranch: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
            end
            StJal, StJalr2: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            StJalr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            StLui: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            StAuipc: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            default: ;
        endcase
    end

    // Reset gates every side-effecting strobe so no partial access or write can complete.
    always_comb begin
        MemReq   = mem_req & ~reset;
        PCWrite  = (pc_update | ((state_q == StBranch) & BranchCond)) & ~reset;
        MemWrite = mem_write & ~reset;
        IRWrite  = ir_write & ~reset;
        RegWrite = reg_write & ~reset;
        Illegal  = illegal & ~reset;
    end

    always_comb begin
        case (op)
            OpLoad, OpI, OpJalr, OpR: ImmSrc = 3'b000;
            OpStore:                  ImmSrc = 3'b001;
            OpBranch:                 ImmSrc = 3'b010;
            OpJal:                    ImmSrc = 3'b011;
            OpLui, OpAuipc:           ImmSrc = 3'b100;
            default:                  ImmSrc = 3'bxxx;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: stimulus pushes hand-computed per-cycle output vectors,
// a negedge monitor pops and compares them.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       BranchCond, MemReady;
    logic       MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .BranchCond(BranchCond), .MemReady(MemReady),
        .MemReq(MemReq), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    // {MemReq,PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,Illegal}
    logic [14:0] outvec;
    assign outvec = {MemReq, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                     ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal};

    localparam logic [14:0] VFetch  = 15'b1_1_0_0_1_0_10_00_10_00_0;
    localparam logic [14:0] VFetchW = 15'b1_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] VReset  = 15'b0_0_0_0_0_0_10_00_10_00_0;
    localparam logic [14:0] VDecode = 15'b0_0_0_0_0_0_00_01_01_00_0;
    localparam logic [14:0] VDecIll = 15'b0_0_0_0_0_0_00_01_01_00_1;
    localparam logic [14:0] VExecR  = 15'b0_0_0_0_0_0_00_10_00_10_0;
    localparam logic [14:0] VExecI  = 15'b0_0_0_0_0_0_00_10_01_10_0;
    localparam logic [14:0] VAluWb  = 15'b0_0_0_0_0_1_00_00_00_00_0;
    localparam logic [14:0] VMemAdr = 15'b0_0_0_0_0_0_00_10_01_00_0;
    localparam logic [14:0] VMemRd  = 15'b1_0_1_0_0_0_00_00_00_00_0;
    localparam logic [14:0] VMemWb  = 15'b0_0_0_0_0_1_01_00_00_00_0;
    localparam logic [14:0] VMemWr  = 15'b1_0_1_1_0_0_00_00_00_00_0;
    localparam logic [14:0] VBrT    = 15'b0_1_0_0_0_0_00_10_00_01_0;
    localparam logic [14:0] VBrN    = 15'b0_0_0_0_0_0_00_10_00_01_0;
    localparam logic [14:0] VJal    = 15'b0_1_0_0_0_0_00_01_10_00_0;
    localparam logic [14:0] VJalr   = 15'b0_0_0_0_0_0_00_10_01_00_0;
    localparam logic [14:0] VLui    = 15'b0_0_0_0_0_0_00_11_01_00_0;
    localparam logic [14:0] VAuipc  = 15'b0_0_0_0_0_0_00_01_01_00_0;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpBad    = 7'b1111111;

    typedef struct {
        logic [14:0] v;
        logic [2:0]  imm;
        bit          imm_chk;
        string       name;
    } sb_item_t;

    sb_item_t sb[$];
    sb_item_t mon_item;
    int checks = 0;
    int errors = 0;
    logic [2:0] cur_imm = 3'b000;
    bit         cur_chk = 1'b0;

    task automatic check(input string nm, input logic [14:0] act, input logic [14:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Drive one cycle (entered at posedge+1) and queue what the DUT should show this cycle.
    task automatic step(input logic [6:0] o, input logic r, input logic bc,
                        input logic [14:0] v, input string nm);
        op         = o;
        MemReady   = r;
        BranchCond = bc;
        sb.push_back('{v: v, imm: cur_imm, imm_chk: cur_chk, name: nm});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_item = sb.pop_front();
            check(mon_item.name, outvec, mon_item.v);
            if (mon_item.imm_chk)
                check({mon_item.name, "/imm"}, {12'b0, ImmSrc}, {12'b0, mon_item.imm});
        end
    end

    initial begin
        reset = 1'b1; op = OpR; MemReady = 1'b1; BranchCond = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outvec, VReset);
        reset = 1'b0;

        // R-type, MemReady ignored in EXECR/ALUWB
        cur_chk = 1'b0;
        step(OpR, 1, 0, VFetch,  "r_fetch");
        step(OpR, 0, 0, VDecode, "r_decode");
        step(OpR, 0, 0, VExecR,  "r_execr");
        step(OpR, 0, 0, VAluWb,  "r_aluwb");

        // lw with two wait states in MEMREAD
        cur_imm = 3'b000; cur_chk = 1'b1;
        step(OpLoad, 1, 0, VFetch,  "lw_fetch");
        step(OpLoad, 1, 0, VDecode, "lw_decode");
        step(OpLoad, 1, 0, VMemAdr, "lw_memadr");
        step(OpLoad, 0, 0, VMemRd,  "lw_memread_w1");
        step(OpLoad, 0, 0, VMemRd,  "lw_memread_w2");
        step(OpLoad, 1, 0, VMemRd,  "lw_memread");
        step(OpLoad, 1, 0, VMemWb,  "lw_memwb");

        // branch taken, then not taken with a fetch stall
        cur_imm = 3'b010;
        step(OpBranch, 1, 0, VFetch,  "bt_fetch");
        step(OpBranch, 1, 0, VDecode, "bt_decode");
        step(OpBranch, 1, 1, VBrT,    "bt_branch");
        step(OpBranch, 0, 1, VFetchW, "bn_fetch_wait");
        step(OpBranch, 1, 1, VFetch,  "bn_fetch");
        step(OpBranch, 1, 0, VDecode, "bn_decode");
        step(OpBranch, 1, 0, VBrN,    "bn_branch");

        // jalr
        cur_imm = 3'b000;
        step(OpJalr, 1, 0, VFetch,  "jalr_fetch");
        step(OpJalr, 1, 0, VDecode, "jalr_decode");
        step(OpJalr, 1, 0, VJalr,   "jalr_target");
        step(OpJalr, 1, 0, VJal,    "jalr_link");
        step(OpJalr, 1, 0, VAluWb,  "jalr_aluwb");

        // illegal opcode
        cur_chk = 1'b0;
        step(OpBad, 1, 0, VFetch,  "ill_fetch");
        step(OpBad, 1, 0, VDecIll, "ill_decode");

        // I-type, JAL (BranchCond must not leak outside BRANCH), LUI, AUIPC
        cur_imm = 3'b000; cur_chk = 1'b1;
        step(OpI, 1, 0, VFetch,  "i_fetch");
        step(OpI, 1, 0, VDecode, "i_decode");
        step(OpI, 1, 0, VExecI,  "i_execi");
        step(OpI, 1, 0, VAluWb,  "i_aluwb");
        cur_imm = 3'b011;
        step(OpJal, 1, 1, VFetch,  "jal_fetch");
        step(OpJal, 1, 1, VDecode, "jal_decode");
        step(OpJal, 1, 1, VJal,    "jal_jal");
        step(OpJal, 1, 1, VAluWb,  "jal_aluwb");
        cur_imm = 3'b100;
        step(OpLui, 1, 0, VFetch,  "lui_fetch");
        step(OpLui, 1, 0, VDecode, "lui_decode");
        step(OpLui, 1, 0, VLui,    "lui_lui");
        step(OpLui, 1, 0, VAluWb,  "lui_aluwb");
        step(OpAuipc, 1, 0, VFetch,  "auipc_fetch");
        step(OpAuipc, 1, 0, VDecode, "auipc_decode");
        step(OpAuipc, 1, 0, VAuipc,  "auipc_auipc");
        step(OpAuipc, 1, 0, VAluWb,  "auipc_aluwb");

        // sw with zero wait states
        cur_imm = 3'b001;
        step(OpStore, 1, 0, VFetch,  "sw_fetch");
        step(OpStore, 1, 0, VDecode, "sw_decode");
        step(OpStore, 1, 0, VMemAdr, "sw_memadr");
        step(OpStore, 1, 0, VMemWr,  "sw_memwrite");

        // sw stalled in MEMWRITE, then an asynchronous reset pulse
        step(OpStore, 1, 0, VFetch,  "swr_fetch");
        step(OpStore, 1, 0, VDecode, "swr_decode");
        step(OpStore, 1, 0, VMemAdr, "swr_memadr");
        step(OpStore, 0, 0, VMemWr,  "swr_memwrite_wait");
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_drop", outvec, VReset);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cur_chk = 1'b0;
        step(OpR, 1, 0, VFetch,  "post_reset_fetch");
        step(OpR, 1, 0, VDecode, "post_reset_decode");
        step(OpR, 1, 0, VExecR,  "post_reset_execr");
        step(OpR, 1, 0, VAluWb,  "post_reset_aluwb");

        @(negedge clk);
        #1;
        check("scoreboard_drained", 15'(sb.size()), 15'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
